// File: rtl/pred_pkg.sv
// Shared definitions for the predictor merge path: word layout and source codes.
package pred_pkg;

    localparam int PRED_W   = 46;
    localparam int CUT_LSB  = 0;
    localparam int TYPE_LSB = 8;
    localparam int JPOS_LSB = 11;
    localparam int ADDR_LSB = 14;

    localparam logic [1:0] SRC_NBJ    = 2'd0;
    localparam logic [1:0] SRC_NORMAL = 2'd1;
    localparam logic [1:0] SRC_B      = 2'd2;

    // Round-robin successor over the three sources: nbj -> normal -> b -> nbj.
    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == SRC_B) ? SRC_NBJ : src + 2'd1;
    endfunction

endpackage

// File: rtl/pred_out_fifo.sv
// Small register FIFO holding merged prediction words plus their source index.
module pred_out_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // No bypass: a full FIFO refuses a push even when the head leaves this cycle.
    assign do_push = push && (count != CNT_W'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pred_merge_arbiter.sv
// Round-robin merge of the nbj/normal/b prediction paths into one buffered stream for iQueue.
module pred_merge_arbiter
    import pred_pkg::*;
#(
    parameter int DATA_W   = PRED_W,
    parameter int DEPTH    = 2,
    parameter int ROOM_MIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive0,
    input  logic              i_drive1,
    input  logic              i_drive2,
    input  logic [DATA_W-1:0] i_data0_46,
    input  logic [DATA_W-1:0] i_data1_46,
    input  logic [DATA_W-1:0] i_data2_46,
    input  logic [7:0]        i_room_8,
    input  logic              i_flush,
    input  logic              i_freeNext,
    output logic              o_free0,
    output logic              o_free1,
    output logic              o_free2,
    output logic              o_driveNext,
    output logic [DATA_W-1:0] o_data_46,
    output logic [1:0]        o_src_2,
    output logic              o_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2:0]        drive;
    logic [2:0]        free_q;
    logic [2:0]        elig;
    logic [2:0]        grant;
    logic              grant_en;
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_src;
    logic [DATA_W-1:0] gnt_data;
    logic [DATA_W+1:0] head;
    logic [CNT_W-1:0]  count;

    assign drive = {i_drive2, i_drive1, i_drive0};
    // A requester still shows drive in the cycle its free pulses; mask it for that cycle.
    assign elig  = drive & ~free_q;

    assign grant_en = (count < CNT_W'(DEPTH))
                   && ({1'b0, i_room_8} >= 9'(ROOM_MIN) + 9'(count))
                   && !i_flush;

    always_comb begin
        grant = '0;
        if (grant_en) begin
            case (rr_ptr)
                SRC_NBJ: begin
                    if      (elig[0]) grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                end
                SRC_NORMAL: begin
                    if      (elig[1]) grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                end
                default: begin
                    if      (elig[2]) grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                end
            endcase
        end
    end

    always_comb begin
        gnt_src  = SRC_NBJ;
        gnt_data = i_data0_46;
        if (grant[1]) begin
            gnt_src  = SRC_NORMAL;
            gnt_data = i_data1_46;
        end
        if (grant[2]) begin
            gnt_src  = SRC_B;
            gnt_data = i_data2_46;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_q <= '0;
            rr_ptr <= SRC_NBJ;
        end else begin
            free_q <= grant;
            if (grant != '0) begin
                rr_ptr <= rr_next(gnt_src);
            end
        end
    end

    pred_out_fifo #(
        .W     (DATA_W + 2),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant != '0),
        .push_data ({gnt_src, gnt_data}),
        .pop       (i_freeNext),
        .flush     (i_flush),
        .head      (head),
        .count     (count)
    );

    assign o_free0     = free_q[0];
    assign o_free1     = free_q[1];
    assign o_free2     = free_q[2];
    assign o_driveNext = (count != '0);
    assign o_data_46   = head[DATA_W-1:0];
    assign o_src_2     = head[DATA_W+1:DATA_W];
    assign o_full      = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_pred_merge_arbiter.sv
// Bench for pred_merge_arbiter: vector table, hand-written corner sequences, random run against a queue model.
module tb_pred_merge_arbiter;
  import pred_pkg::*;

  localparam int DW       = PRED_W;
  localparam int DEPTH    = 2;
  localparam int ROOM_MIN = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_drive0, i_drive1, i_drive2;
  logic [DW-1:0] i_data0_46, i_data1_46, i_data2_46;
  logic [7:0]    i_room_8;
  logic          i_flush, i_freeNext;
  logic          o_free0, o_free1, o_free2;
  logic          o_driveNext;
  logic [DW-1:0] o_data_46;
  logic [1:0]    o_src_2;
  logic          o_full;

  int checks = 0;
  int errors = 0;

  pred_merge_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .ROOM_MIN(ROOM_MIN)) dut (
    .clk(clk), .rst(rst),
    .i_drive0(i_drive0), .i_drive1(i_drive1), .i_drive2(i_drive2),
    .i_data0_46(i_data0_46), .i_data1_46(i_data1_46), .i_data2_46(i_data2_46),
    .i_room_8(i_room_8), .i_flush(i_flush), .i_freeNext(i_freeNext),
    .o_free0(o_free0), .o_free1(o_free1), .o_free2(o_free2),
    .o_driveNext(o_driveNext), .o_data_46(o_data_46), .o_src_2(o_src_2), .o_full(o_full)
  );

  // clock
  always #5 clk = ~clk;

  // requester protocol: drive may only fall in the cycle its free pulses
  logic [2:0] drv_q;
  logic       rst_q;
  always @(posedge clk) begin
    if (rst && rst_q) begin
      assert (!(drv_q[0] && !i_drive0 && !o_free0)) else $error("protocol: requester 0 dropped drive");
      assert (!(drv_q[1] && !i_drive1 && !o_free1)) else $error("protocol: requester 1 dropped drive");
      assert (!(drv_q[2] && !i_drive2 && !o_free2)) else $error("protocol: requester 2 dropped drive");
    end
    drv_q <= {i_drive2, i_drive1, i_drive0};
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] ef, input logic edn,
                            input logic [DW-1:0] ed, input logic [1:0] es, input logic efull);
    chk($sformatf("%s.free", name), 64'({o_free2, o_free1, o_free0}), 64'(ef));
    chk($sformatf("%s.driveNext", name), 64'(o_driveNext), 64'(edn));
    if (edn) begin
      chk($sformatf("%s.data", name), 64'(o_data_46), 64'(ed));
      chk($sformatf("%s.src", name), 64'(o_src_2), 64'(es));
    end
    chk($sformatf("%s.full", name), 64'(o_full), 64'(efull));
  endtask

  // driver tasks
  task automatic set_in(input logic [2:0] drv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [7:0] room, input logic fn, input logic fl);
    {i_drive2, i_drive1, i_drive0} = drv;
    i_data0_46 = d0;
    i_data1_46 = d1;
    i_data2_46 = d2;
    i_room_8   = room;
    i_freeNext = fn;
    i_flush    = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(3'b000, '0, '0, '0, 8'd8, 1'b0, 1'b0);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    drv;
    logic [DW-1:0] data;
    logic [7:0]    room;
    logic          fn;
    logic          fl;
    logic [2:0]    e_free;
    logic          e_dn;
    logic [DW-1:0] e_data;
    logic [1:0]    e_src;
    logic          e_full;
  } vec_t;

  vec_t vecs[8];

  // scoreboard / reference model state
  logic [DW+1:0] exp_q[$];
  logic [2:0]    mfree;
  int            mptr;
  logic [2:0]    drv_r;
  logic [DW-1:0] data_r[3];

  initial begin
    rst = 1'b0;
    set_in(3'b000, '0, '0, '0, 8'd0, 1'b0, 1'b0);
    repeat (2) cycle();

    // reset state
    check_outs("reset", 3'b000, 1'b0, '0, 2'd0, 1'b0);
    chk("reset.data", 64'(o_data_46), 64'd0);
    chk("reset.src", 64'(o_src_2), 64'd0);
    rst = 1'b1;

    // single request, pop, then room gating
    vecs[0] = '{3'b010, 46'h1234, 8'd8, 1'b0, 1'b0, 3'b010, 1'b1, 46'h1234, 2'd1, 1'b0};
    vecs[1] = '{3'b000, 46'h0,    8'd8, 1'b1, 1'b0, 3'b000, 1'b0, 46'h0,    2'd0, 1'b0};
    vecs[2] = '{3'b001, 46'h0AAA, 8'd1, 1'b0, 1'b0, 3'b001, 1'b1, 46'h0AAA, 2'd0, 1'b0};
    vecs[3] = '{3'b001, 46'h0BBB, 8'd1, 1'b0, 1'b0, 3'b000, 1'b1, 46'h0AAA, 2'd0, 1'b0};
    vecs[4] = '{3'b001, 46'h0BBB, 8'd1, 1'b0, 1'b0, 3'b000, 1'b1, 46'h0AAA, 2'd0, 1'b0};
    vecs[5] = '{3'b001, 46'h0BBB, 8'd2, 1'b0, 1'b0, 3'b001, 1'b1, 46'h0AAA, 2'd0, 1'b1};
    vecs[6] = '{3'b000, 46'h0,    8'd8, 1'b1, 1'b0, 3'b000, 1'b1, 46'h0BBB, 2'd0, 1'b0};
    vecs[7] = '{3'b000, 46'h0,    8'd8, 1'b1, 1'b0, 3'b000, 1'b0, 46'h0,    2'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].drv, vecs[i].data, vecs[i].data, vecs[i].data, vecs[i].room, vecs[i].fn, vecs[i].fl);
      cycle();
      check_outs($sformatf("vec%0d", i), vecs[i].e_free, vecs[i].e_dn, vecs[i].e_data, vecs[i].e_src, vecs[i].e_full);
    end

    // fairness: all drives held, pop every cycle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(3'b111, 46'h100, 46'h101, 46'h102, 8'd8, 1'b1, 1'b0);
      cycle();
      check_outs($sformatf("fair%0d", k), 3'(1 << (k % 3)), 1'b1, DW'(46'h100 + (k % 3)), 2'(k % 3), 1'b0);
    end

    // backpressure: no pops, FIFO fills, one pop frees one slot
    do_reset();
    set_in(3'b111, 46'h10, 46'h20, 46'h30, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("bp0", 3'b001, 1'b1, 46'h10, 2'd0, 1'b0);
    cycle(); check_outs("bp1", 3'b010, 1'b1, 46'h10, 2'd0, 1'b1);
    cycle(); check_outs("bp2", 3'b000, 1'b1, 46'h10, 2'd0, 1'b1);
    cycle(); check_outs("bp3", 3'b000, 1'b1, 46'h10, 2'd0, 1'b1);
    i_freeNext = 1'b1;
    cycle(); check_outs("bp4", 3'b000, 1'b1, 46'h20, 2'd1, 1'b0);
    i_freeNext = 1'b0;
    cycle(); check_outs("bp5", 3'b100, 1'b1, 46'h20, 2'd1, 1'b1);
    cycle(); check_outs("bp6", 3'b000, 1'b1, 46'h20, 2'd1, 1'b1);

    // flush with FIFO full and a new request in the same cycle
    do_reset();
    set_in(3'b011, 46'h41, 46'h42, 46'h43, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("fl0", 3'b001, 1'b1, 46'h41, 2'd0, 1'b0);
    set_in(3'b010, 46'h41, 46'h42, 46'h43, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("fl1", 3'b010, 1'b1, 46'h41, 2'd0, 1'b1);
    set_in(3'b100, 46'h41, 46'h42, 46'h43, 8'd8, 1'b1, 1'b1);
    cycle(); check_outs("fl2", 3'b000, 1'b0, '0, 2'd0, 1'b0);
    set_in(3'b100, 46'h41, 46'h42, 46'h43, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("fl3", 3'b100, 1'b1, 46'h43, 2'd2, 1'b0);
    set_in(3'b000, 46'h41, 46'h42, 46'h43, 8'd8, 1'b1, 1'b0);
    cycle(); check_outs("fl4", 3'b000, 1'b0, '0, 2'd0, 1'b0);

    // asynchronous reset while a free is pending and the FIFO is full
    do_reset();
    set_in(3'b010, 46'h51, 46'h52, 46'h53, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("ar0", 3'b010, 1'b1, 46'h52, 2'd1, 1'b0);
    set_in(3'b001, 46'h51, 46'h52, 46'h53, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("ar1", 3'b001, 1'b1, 46'h52, 2'd1, 1'b1);
    #2;
    rst = 1'b0;
    set_in(3'b000, 46'h51, 46'h52, 46'h53, 8'd8, 1'b0, 1'b0);
    #1;
    check_outs("ar_async", 3'b000, 1'b0, '0, 2'd0, 1'b0);
    chk("ar_async.data", 64'(o_data_46), 64'd0);
    chk("ar_async.src", 64'(o_src_2), 64'd0);
    cycle();
    rst = 1'b1;
    set_in(3'b111, 46'h51, 46'h52, 46'h53, 8'd8, 1'b0, 1'b0);
    cycle(); check_outs("ar_after", 3'b001, 1'b1, 46'h51, 2'd0, 1'b0);

    // randomized run against the queue model
    do_reset();
    exp_q.delete();
    mfree = '0;
    mptr  = 0;
    drv_r = '0;
    for (int n = 0; n < 3; n++) data_r[n] = '0;
    for (int t = 0; t < 3000; t++) begin
      logic [7:0] room;
      logic       fn, fl, en;
      logic [2:0] elig;
      int         g;
      check_outs("rand", mfree, exp_q.size() != 0,
                 (exp_q.size() != 0) ? exp_q[0][DW-1:0] : '0,
                 (exp_q.size() != 0) ? exp_q[0][DW+1:DW] : 2'd0,
                 exp_q.size() == DEPTH);
      for (int n = 0; n < 3; n++) begin
        if (mfree[n]) begin
          if ($urandom_range(0, 9) < 7) begin
            drv_r[n]  = 1'b1;
            data_r[n] = DW'({$urandom(), $urandom()});
          end else begin
            drv_r[n] = 1'b0;
          end
        end else if (!drv_r[n] && $urandom_range(0, 1) == 1) begin
          drv_r[n]  = 1'b1;
          data_r[n] = DW'({$urandom(), $urandom()});
        end
      end
      room = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      fn   = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 29) == 0);
      set_in(drv_r, data_r[0], data_r[1], data_r[2], room, fn, fl);

      // model: eligible requesters, gated grant in rotating order
      elig = drv_r & ~mfree;
      en   = (exp_q.size() < DEPTH) && (int'(room) >= ROOM_MIN + exp_q.size()) && !fl;
      g    = -1;
      if (en) begin
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && elig[(mptr + k) % 3]) g = (mptr + k) % 3;
        end
      end
      mfree = '0;
      if (g >= 0) begin
        mfree[g] = 1'b1;
        mptr     = (g + 1) % 3;
      end
      if (fl) begin
        exp_q.delete();
      end else begin
        if (fn && exp_q.size() != 0) void'(exp_q.pop_front());
        if (g >= 0) exp_q.push_back({2'(g), data_r[g]});
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_merge_arbiter.md
Name: pred_merge_arbiter

Overview:
- Clocked three-way arbiter that merges the nbj, normal and b prediction paths into the single 46-bit stream feeding the instruction queue.
- Grants one requester per cycle, round-robin.
- Buffers accepted words in a small output FIFO.
- Withholds grants when the queue reports insufficient room.
- Sits between the three predictor sub-processes and iQueue, and replaces the free-running mutex merge in the clocked predictor variant.

Parameters:
- DATA_W, 46: word width {predictAddr[45:14], firstJPos[13:11], type[10:8], cutPosition[7:0]}.
- DEPTH, 2: output FIFO entries (2 or 4).
- ROOM_MIN, 1: minimum free queue slots required beyond entries already buffered.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_drive0..2  in  1 each  request from nbj(0), normal(1), b(2). Held high with data until the matching free.
- i_data0_46..i_data2_46  in  DATA_W each  request payloads.
- i_room_8  in  8  free queue slots reported by iQueue.
- i_flush  in  1  pipeline redirect; drops buffered words.
- i_freeNext  in  1  one-cycle pulse: queue consumed head word.
- o_free0..2  out  1 each  one-cycle acceptance pulse to requester.
- o_driveNext  out  1  head word valid.
- o_data_46  out  DATA_W  head word.
- o_src_2  out  2  source index of head word.
- o_full  out  1  FIFO full.

Behaviour:
- Reset (rst low, async) clears the following: FIFO count=0, o_driveNext=0, o_data_46=0, o_src_2=0, o_free0..2=0, o_full=0, round-robin pointer=0 (nbj highest).
- Eligibility, requester N in cycle T: i_driveN=1 AND o_freeN=0. The mask covers the one cycle in which the requester has not yet seen its free.
- Grant enable, cycle T: count<DEPTH AND i_room_8 >= ROOM_MIN+count AND i_flush=0.
- Arbitration:
  - Pick the first eligible requester starting at the pointer, in order 0→1→2→0.
  - After a grant to N, pointer = (N+1) mod 3.
  - Pointer holds when there is no grant.
- Grant effects at the clock edge ending T:
  - i_dataN_46 and N are pushed to the FIFO tail.
  - o_freeN=1 for exactly cycle T+1.
  - Latency is request-to-free 1 cycle, and request-to-o_driveNext 1 cycle when the FIFO is empty.
- Output:
  - o_driveNext = (count!=0).
  - o_data_46 and o_src_2 present the head entry.
  - Head is stable while o_driveNext=1 and no pop occurs.
- Pop: i_freeNext=1 with count!=0 removes the head. i_freeNext with count=0 is ignored.
- Simultaneous push and pop: count unchanged, order preserved.
- Full: push is not permitted at count=DEPTH, even with a same-cycle pop; no bypass.
- o_full = (count==DEPTH), registered with count.
- Count arithmetic: width clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Room comparison is unsigned 8-bit against ROOM_MIN+count, zero-extended.
- Flush:
  - i_flush=1 in T suppresses any grant in T and sets count=0 at the T edge.
  - A pop in the same cycle is absorbed.
  - A free already scheduled from a grant in T-1 still pulses in T, because that request was consumed.
  - Round-robin pointer unchanged.
- Reset mid-operation: all state is lost immediately, including a pending o_free pulse. Requesters are reset by the same rst.
- A requester that drops drive before its free is a protocol violation; the bench asserts this.

Decomposition:
- Shared package pred_pkg holds:
  - field offsets (CUT_LSB=0, TYPE_LSB=8, JPOS_LSB=11, ADDR_LSB=14);
  - PRED_W=46;
  - source codes SRC_NBJ=0, SRC_NORMAL=1, SRC_B=2.
- One sub-module is natural: pred_out_fifo, a parameterised DEPTH×(DATA_W+2) register FIFO with push/pop/flush and count.
- The round-robin arbiter stays inline.

Test Plan:
- Single request: i_drive1=1, data=46'h1234, room=8 → o_free1 pulses in cycle 2; o_driveNext=1, o_data_46=46'h1234, o_src_2=1 in cycle 2; i_freeNext in cycle 3 → o_driveNext=0 in cycle 4.
- Fairness: all three drives held, requesters re-raise immediately, queue pops every cycle → grant order 0,1,2,0,1,2; each o_free exactly once per 3 grants; no requester granted in two consecutive cycles.
- Backpressure: i_freeNext=0, DEPTH=2, all drives high → exactly 2 grants, then o_full=1 and no further o_free. One i_freeNext → exactly one more grant the following cycle.
- Room gating: i_room_8=1, ROOM_MIN=1, count=0 → one grant, then no grant while count=1. i_room_8=2 → next grant proceeds.
- Flush: FIFO holds 2 words, i_flush plus i_drive2 in the same cycle → next cycle count=0, o_driveNext=0, o_free2=0. Following cycle grants 2 normally.
- Async reset: assert rst low mid-cycle while o_free0=1 and count=2 → all outputs 0 immediately, without waiting for a clock edge. After release, first grant goes to requester 0.
